// File: rtl/ysyx_25040109_csr_ctrl.sv
// CSR access and trap sequencer driving the register file's single CSR port.
// Latency: CSR op done at N+2, ECALL at N+4, MRET at N+2, illegal op at N+1 after accept.
// Backpressure: req_ready only in IDLE, so one request is in flight at a time.
module ysyx_25040109_csr_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_src_zero,
  input  logic [31:0]           req_pc,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  output logic                  done_valid,
  output logic [DATA_WIDTH-1:0] done_rdata,
  output logic                  redirect,
  output logic [31:0]           redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_T_EPC, S_T_CAUSE, S_T_STAT, S_R_STAT, S_DONE
  } state_t;

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  state_t                state;
  logic [2:0]            op_q;
  logic [11:0]           csr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  src_zero_q;
  logic [31:0]           pc_q;

  assign req_ready = (state == S_IDLE);

  // Sequencer: latch the request on accept, then walk the fixed access sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      csr_q      <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      pc_q       <= '0;
      done_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            csr_q      <= req_csr;
            src_q      <= req_src;
            src_zero_q <= req_src_zero;
            pc_q       <= req_pc;
            // Non-CSR ops report 0 for rd; CSR ops overwrite this in EXEC.
            done_rdata <= '0;
            case (req_op)
              OP_RW, OP_RS, OP_RC: state <= S_EXEC;
              OP_ECALL:            state <= S_T_EPC;
              OP_MRET:             state <= S_R_STAT;
              default:             state <= S_DONE;
            endcase
          end
        end
        S_EXEC: begin
          done_rdata <= csr_rdata;
          state      <= S_DONE;
        end
        S_T_EPC:   state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_STAT;
        S_T_STAT:  state <= S_DONE;
        S_R_STAT:  state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // CSR port drive: write data depends on the live read of the addressed CSR.
  always_comb begin
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    case (state)
      S_EXEC: begin
        csr_addr = csr_q;
        case (op_q)
          OP_RS:   csr_wdata = csr_rdata | src_q;
          OP_RC:   csr_wdata = csr_rdata & ~src_q;
          default: csr_wdata = src_q;
        endcase
        // Set/clear with a zero source is a pure read and must not write.
        csr_we = !((op_q != OP_RW) && src_zero_q);
      end
      S_T_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = DATA_WIDTH'(pc_q);
      end
      S_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = DATA_WIDTH'(ECALL_CAUSE);
      end
      S_T_STAT: begin
        csr_we         = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_wdata      = csr_rdata;
        csr_wdata[7]   = csr_rdata[3];
        csr_wdata[3]   = 1'b0;
        csr_wdata[12:11] = 2'b11;
      end
      S_R_STAT: begin
        csr_we         = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_wdata      = csr_rdata;
        csr_wdata[3]   = csr_rdata[7];
        csr_wdata[7]   = 1'b1;
        csr_wdata[12:11] = 2'b11;
      end
      default: ;
    endcase
  end

  // Completion: target PC is read in DONE so the trap-entry writes are already visible.
  always_comb begin
    done_valid  = (state == S_DONE);
    redirect    = 1'b0;
    redirect_pc = '0;
    if (state == S_DONE) begin
      if (op_q == OP_ECALL) begin
        redirect    = 1'b1;
        redirect_pc = mtvec_in[31:0];
      end else if (op_q == OP_MRET) begin
        redirect    = 1'b1;
        redirect_pc = mepc_in[31:0];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_csr_ctrl.sv
// Directed bench for the CSR/trap sequencer with a small CSR register file model.
module tb_ysyx_25040109_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic [31:0] req_pc;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ysyx_25040109_csr_ctrl #(.DATA_WIDTH(32), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .done_valid(done_valid), .done_rdata(done_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // CSR register file model: combinational read, write on clock edge, unknown CSRs read 0.
  logic [31:0] m_mstatus = '0;
  logic [31:0] m_mtvec   = '0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign mtvec_in = m_mtvec;
  assign mepc_in  = m_mepc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle (accept cycle N); returns at N+1 with inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                       input logic sz, input logic [31:0] pc);
    req_valid = 1'b1; req_op = op; req_csr = csr; req_src = src; req_src_zero = sz; req_pc = pc;
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0; req_op = 3'd7; req_csr = 12'hFFF; req_src = 32'hDEADBEEF;
    req_src_zero = ~sz; req_pc = 32'h0BADF00D;
  endtask

  // Full CSR instruction: check write at N+1, completion at N+2, idle at N+3.
  task automatic csr_op(input string tag, input logic [2:0] op, input logic [11:0] csr,
                        input logic [31:0] src, input logic sz, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    issue(op, csr, src, sz, 32'h0);
    chk({tag, "_we"}, {31'd0, csr_we}, {31'd0, exp_we});
    chk({tag, "_addr"}, {20'd0, csr_addr}, {20'd0, csr});
    if (exp_we) chk({tag, "_wdata"}, csr_wdata, exp_wdata);
    chk({tag, "_busy"}, {30'd0, req_ready, done_valid}, 32'd0);
    step();
    chk({tag, "_done"}, {29'd0, done_valid, redirect, csr_we}, 32'b100);
    chk({tag, "_rdata"}, done_rdata, exp_rdata);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd0);
    step();
    chk({tag, "_idle"}, {30'd0, req_ready, done_valid}, 32'b10);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_csr = '0; req_src = '0;
    req_src_zero = 1'b0; req_pc = '0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ctl", {29'd0, csr_we, done_valid, redirect}, 32'd0);
    chk("rst_rdata", done_rdata, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_port", {8'd0, csr_addr, 12'd0} | csr_wdata, 32'd0);
    #1 rst_n = 1'b1;
    step();

    csr_op("rw_mtvec", 3'd0, 12'h305, 32'h80000100, 1'b0, 1'b1, 32'h80000100, 32'h0);
    chk("mtvec_model", m_mtvec, 32'h80000100);
    csr_op("rw_mstatus", 3'd0, 12'h300, 32'h00001800, 1'b0, 1'b1, 32'h00001800, 32'h0);
    csr_op("rs_mstatus", 3'd1, 12'h300, 32'h00000008, 1'b0, 1'b1, 32'h00001808, 32'h1800);
    csr_op("rs_zero", 3'd1, 12'h300, 32'h00000005, 1'b1, 1'b0, 32'h0, 32'h1808);
    csr_op("rw_mcause", 3'd0, 12'h342, 32'h0000001B, 1'b0, 1'b1, 32'h0000001B, 32'h0);
    csr_op("rc_mcause", 3'd2, 12'h342, 32'h0000000F, 1'b0, 1'b1, 32'h00000010, 32'h1B);

    // Illegal op right after a nonzero rdata: must report 0, no write, no redirect.
    issue(3'd6, 12'h300, 32'hFFFFFFFF, 1'b0, 32'h80000000);
    chk("ill_done", {29'd0, done_valid, redirect, csr_we}, 32'b100);
    chk("ill_rdata", done_rdata, 32'd0);
    chk("ill_rpc", redirect_pc, 32'd0);
    step();
    chk("ill_idle", {30'd0, req_ready, done_valid}, 32'b10);

    csr_op("rw_unknown", 3'd0, 12'h7C0, 32'h00001234, 1'b0, 1'b1, 32'h00001234, 32'h0);
    csr_op("rw_mtvec2", 3'd0, 12'h305, 32'h80000200, 1'b0, 1'b1, 32'h80000200, 32'h80000100);
    csr_op("rw_mstatus2", 3'd0, 12'h300, 32'h00000008, 1'b0, 1'b1, 32'h00000008, 32'h1808);

    // ECALL: mepc, mcause, mstatus on N+1..N+3, redirect to mtvec at N+4.
    issue(3'd3, 12'h000, 32'h0, 1'b0, 32'h80000040);
    chk("ecall_epc_we", {31'd0, csr_we}, 32'd1);
    chk("ecall_epc_addr", {20'd0, csr_addr}, 32'h341);
    chk("ecall_epc_wdata", csr_wdata, 32'h80000040);
    step();
    chk("ecall_cause_we", {31'd0, csr_we}, 32'd1);
    chk("ecall_cause_addr", {20'd0, csr_addr}, 32'h342);
    chk("ecall_cause_wdata", csr_wdata, 32'd11);
    step();
    chk("ecall_stat_we", {31'd0, csr_we}, 32'd1);
    chk("ecall_stat_addr", {20'd0, csr_addr}, 32'h300);
    chk("ecall_stat_wdata", csr_wdata, 32'h00001880);
    chk("ecall_busy", {31'd0, done_valid}, 32'd0);
    step();
    chk("ecall_done", {29'd0, done_valid, redirect, csr_we}, 32'b110);
    chk("ecall_rpc", redirect_pc, 32'h80000200);
    chk("ecall_rdata", done_rdata, 32'd0);
    step();
    chk("ecall_idle", {29'd0, req_ready, done_valid, redirect}, 32'b100);

    // mepc written by the trap: old value comes back as rdata.
    csr_op("rw_mepc", 3'd0, 12'h341, 32'h80000044, 1'b0, 1'b1, 32'h80000044, 32'h80000040);

    issue(3'd4, 12'h000, 32'h0, 1'b0, 32'h0);
    chk("mret_stat_we", {31'd0, csr_we}, 32'd1);
    chk("mret_stat_addr", {20'd0, csr_addr}, 32'h300);
    chk("mret_stat_wdata", csr_wdata, 32'h00001888);
    step();
    chk("mret_done", {29'd0, done_valid, redirect, csr_we}, 32'b110);
    chk("mret_rpc", redirect_pc, 32'h80000044);
    step();
    chk("mret_idle", {29'd0, req_ready, done_valid, redirect}, 32'b100);

    // Reset in T_CAUSE: mcause must keep the preloaded 0x55.
    csr_op("rw_mcause2", 3'd0, 12'h342, 32'h00000055, 1'b0, 1'b1, 32'h00000055, 32'd11);
    issue(3'd3, 12'h000, 32'h0, 1'b0, 32'h80000080);
    chk("rst_seq_epc", {20'd0, csr_addr}, 32'h341);
    step();
    chk("rst_seq_cause", {31'd0, csr_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_seq_we", {31'd0, csr_we}, 32'd0);
    chk("rst_seq_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst_post1", {29'd0, req_ready, csr_we, done_valid}, 32'b100);
    step();
    chk("rst_post2", {29'd0, req_ready, csr_we, done_valid}, 32'b100);
    csr_op("rs_mcause_keep", 3'd1, 12'h342, 32'h0, 1'b1, 1'b0, 32'h0, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
